// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the 4-bit adder sequencer: FSM states, operand widths,
// and 7-segment codes (bits[6:0]=g..a active-high, bit7=dp, bit8 unused).
package adder_seq_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = 5;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_READY,
        ST_CONV,
        ST_SHOW
    } state_t;

    localparam logic [8:0] SEG_0 = 9'h03F;
    localparam logic [8:0] SEG_1 = 9'h006;
    localparam logic [8:0] SEG_2 = 9'h05B;
    localparam logic [8:0] SEG_3 = 9'h04F;
    localparam logic [8:0] SEG_4 = 9'h066;
    localparam logic [8:0] SEG_5 = 9'h06D;
    localparam logic [8:0] SEG_6 = 9'h07D;
    localparam logic [8:0] SEG_7 = 9'h007;
    localparam logic [8:0] SEG_8 = 9'h07F;
    localparam logic [8:0] SEG_9 = 9'h06F;

    function automatic logic [8:0] digit_to_seg(input logic [3:0] d);
        logic [8:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = 9'h000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_div10_seq.sv
// Binary-to-two-digit converter by repeated subtract-by-ten, one step per cycle.
// start_i loads the value; ready_o is high once the remainder is below ten.
module bcd_div10_seq
    import adder_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SUM_W-1:0] value_i,
    output logic             ready_o,
    output logic [1:0]       tens_o,
    output logic [3:0]       units_o
);

    logic [SUM_W-1:0] rem_q, rem_d;
    logic [1:0]       tens_q, tens_d;

    always_comb begin
        rem_d  = rem_q;
        tens_d = tens_q;
        if (start_i) begin
            rem_d  = value_i;
            tens_d = 2'd0;
        end else if (rem_q >= SUM_W'(10)) begin
            rem_d  = rem_q - SUM_W'(10);
            tens_d = tens_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            tens_q <= '0;
        end else begin
            rem_q  <= rem_d;
            tens_q <= tens_d;
        end
    end

    assign ready_o = (rem_q < SUM_W'(10));
    assign tens_o  = tens_q;
    assign units_o = rem_q[3:0];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Confirm-key sequencer for the board adder: A entry, B entry, request, decimal convert, show.
// Optional ADDER_SEQ_TIMEOUT_EN auto-clears the SHOW state after TIMEOUT_CYCLES cycles.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfmPulse,
    input  logic [OP_W-1:0]  addNum,
    output logic [SUM_W-1:0] ledSum,
    output logic [8:0]       segLeft,
    output logic [8:0]       segRight,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  opa_q, opa_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] led_q, led_d;
    logic [8:0]       seg_l_q, seg_l_d;
    logic [8:0]       seg_r_q, seg_r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             div_start;
    logic             div_ready;
    logic [1:0]       div_tens;
    logic [3:0]       div_units;

`ifdef ADDER_SEQ_TIMEOUT_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    bcd_div10_seq u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .value_i (sum_q),
        .ready_o (div_ready),
        .tens_o  (div_tens),
        .units_o (div_units)
    );

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        sum_d     = sum_q;
        led_d     = led_q;
        seg_l_d   = seg_l_q;
        seg_r_d   = seg_r_q;
        busy_d    = busy_q;
        done_d    = done_q;
        div_start = 1'b0;
`ifdef ADDER_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_WAIT_A: if (cfmPulse) begin
                opa_d   = addNum;
                seg_l_d = SEG_0;
                seg_r_d = SEG_1;
                state_d = ST_WAIT_B;
            end
            ST_WAIT_B: if (cfmPulse) begin
                sum_d   = {1'b0, opa_q} + {1'b0, addNum};
                led_d   = ~sum_d;
                seg_l_d = SEG_0;
                seg_r_d = SEG_0;
                state_d = ST_READY;
            end
            ST_READY: if (cfmPulse) begin
                div_start = 1'b1;
                busy_d    = 1'b1;
                state_d   = ST_CONV;
            end
            ST_CONV: if (div_ready) begin
                seg_l_d = digit_to_seg({2'b00, div_tens});
                seg_r_d = digit_to_seg(div_units);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
`ifdef ADDER_SEQ_TIMEOUT_EN
                // Expiry mirrors a reset so the board looks freshly powered.
                if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_WAIT_A;
                    opa_d   = '0;
                    sum_d   = '0;
                    led_d   = 5'h1F;
                    seg_l_d = SEG_0;
                    seg_r_d = SEG_2;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_A;
            opa_q   <= '0;
            sum_q   <= '0;
            led_q   <= 5'h1F;
            seg_l_q <= SEG_0;
            seg_r_q <= SEG_2;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDER_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            sum_q   <= sum_d;
            led_q   <= led_d;
            seg_l_q <= seg_l_d;
            seg_r_q <= seg_r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADDER_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ledSum   = led_q;
    assign segLeft  = seg_l_q;
    assign segRight = seg_r_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: vector table, random sums against a decimal model,
// and hand-written sequences for reset-in-CONV, locked SHOW, pulse dropping and timeout.
module tb_adder_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfmPulse;
    logic [3:0] addNum;
    logic [4:0] ledSum;
    logic [8:0] segLeft;
    logic [8:0] segRight;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfmPulse (cfmPulse),
        .addNum   (addNum),
        .ledSum   (ledSum),
        .segLeft  (segLeft),
        .segRight (segRight),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        logic [8:0] left;
        logic [8:0] right;
        logic [4:0] led;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] seg_tab [10];
    vec_t       tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by division, latency = one step per ten plus the exit step.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b);
        vec_t v;
        int   s;
        s       = int'(a) + int'(b);
        v.a     = a;
        v.b     = b;
        v.lat   = s / 10 + 1;
        v.left  = seg_tab[s / 10];
        v.right = seg_tab[s % 10];
        v.led   = ~5'(s);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        cfmPulse = 1'b1;
        addNum   = v;
        tick();
        cfmPulse = 1'b0;
        addNum   = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cfmPulse = 1'b0;
        tick();
        rst      = 1'b0;
    endtask

    // Counts busy cycles from the current one until CONV exits (bounded).
    task automatic count_busy(input int start_n, output int n, output bit overlap);
        n       = start_n;
        overlap = 1'b0;
        while (busy === 1'b1 && n < 16) begin
            if (done !== 1'b0) overlap = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic finish_checks(input vec_t v, input int n, input bit overlap, input string tag);
        check({tag, " latency"}, 32'(n), 32'(v.lat));
        check({tag, " busy/done overlap"}, 32'(overlap), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " segLeft"}, 32'(segLeft), 32'(v.left));
        check({tag, " segRight"}, 32'(segRight), 32'(v.right));
        check({tag, " ledSum"}, 32'(ledSum), 32'(v.led));
    endtask

    task automatic run_seq(input vec_t v, input string tag);
        int n;
        bit ov;
        pulse(v.a);
        check({tag, " disp01 left"}, 32'(segLeft), 32'h03F);
        check({tag, " disp01 right"}, 32'(segRight), 32'h006);
        pulse(v.b);
        check({tag, " led after B"}, 32'(ledSum), 32'(v.led));
        check({tag, " disp00 right"}, 32'(segRight), 32'h03F);
        pulse(4'($urandom_range(0, 15)));
        count_busy(0, n, ov);
        finish_checks(v, n, ov, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        bit   ov;
        vec_t v;

        seg_tab[0] = 9'h03F; seg_tab[1] = 9'h006; seg_tab[2] = 9'h05B; seg_tab[3] = 9'h04F;
        seg_tab[4] = 9'h066; seg_tab[5] = 9'h06D; seg_tab[6] = 9'h07D; seg_tab[7] = 9'h007;
        seg_tab[8] = 9'h07F; seg_tab[9] = 9'h06F;

        //            a      b      lat left    right   led
        tbl.push_back('{4'd3,  4'd4,  1, 9'h03F, 9'h007, 5'b11000});
        tbl.push_back('{4'd15, 4'd15, 4, 9'h04F, 9'h03F, 5'b00001});
        tbl.push_back('{4'd9,  4'd1,  2, 9'h006, 9'h03F, 5'b10101});
        tbl.push_back('{4'd9,  4'd0,  1, 9'h03F, 9'h06F, 5'b10110});
        tbl.push_back('{4'd0,  4'd0,  1, 9'h03F, 9'h03F, 5'b11111});
        tbl.push_back('{4'd10, 4'd9,  2, 9'h006, 9'h06F, 5'b01100});
        tbl.push_back('{4'd12, 4'd8,  3, 9'h05B, 9'h03F, 5'b01011});

        rst      = 1'b1;
        cfmPulse = 1'b0;
        addNum   = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset segLeft", 32'(segLeft), 32'h03F);
        check("reset segRight", 32'(segRight), 32'h05B);
        check("reset ledSum", 32'(ledSum), 32'h1F);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);

        foreach (tbl[i]) begin
            do_reset();
            run_seq(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            do_reset();
            run_seq(model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))),
                    $sformatf("rnd%0d", i));
        end

        // SHOW ignores further confirm pulses.
        do_reset();
        run_seq(model(4'd3, 4'd4), "lock");
        pulse(4'd5);
        pulse(4'd6);
        check("lock segLeft", 32'(segLeft), 32'h03F);
        check("lock segRight", 32'(segRight), 32'h007);
        check("lock done", 32'(done), 32'd1);
        check("lock ledSum", 32'(ledSum), 32'h18);

        // Reset during the 2nd CONV cycle, then a normal run without another reset.
        do_reset();
        pulse(4'd15);
        pulse(4'd15);
        pulse(4'd0);
        tick();
        check("midconv busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midconv rst busy", 32'(busy), 32'd0);
        check("midconv rst done", 32'(done), 32'd0);
        check("midconv rst left", 32'(segLeft), 32'h03F);
        check("midconv rst right", 32'(segRight), 32'h05B);
        check("midconv rst led", 32'(ledSum), 32'h1F);
        run_seq(model(4'd2, 4'd2), "after_rst");

        // Pulse during CONV does not disturb the conversion.
        do_reset();
        pulse(4'd15);
        pulse(4'd15);
        cfmPulse = 1'b1;
        tick();
        check("conv_cfm busy", 32'(busy), 32'd1);
        tick();
        cfmPulse = 1'b0;
        count_busy(1, n, ov);
        finish_checks(model(4'd15, 4'd15), n, ov, "conv_cfm");

        // Pulse on the CONV exit cycle is dropped.
        do_reset();
        pulse(4'd3);
        pulse(4'd4);
        pulse(4'd1);
        pulse(4'd9);
        finish_checks(model(4'd3, 4'd4), 1, 1'b0, "exit_cfm");
        tick();
        check("exit_cfm hold right", 32'(segRight), 32'h007);

        // Back-to-back pulses advance one state each.
        do_reset();
        cfmPulse = 1'b1;
        addNum   = 4'd6;
        tick();
        addNum = 4'd7;
        tick();
        addNum = 4'd2;
        tick();
        cfmPulse = 1'b0;
        count_busy(0, n, ov);
        finish_checks(model(4'd6, 4'd7), n, ov, "b2b");

`ifdef ADDER_SEQ_TIMEOUT_EN
        do_reset();
        run_seq(model(4'd3, 4'd4), "tmo");
        repeat (7) tick();
        check("tmo still done", 32'(done), 32'd1);
        tick();
        check("tmo done cleared", 32'(done), 32'd0);
        check("tmo left", 32'(segLeft), 32'h03F);
        check("tmo right", 32'(segRight), 32'h05B);
        check("tmo led", 32'(ledSum), 32'h1F);
        run_seq(model(4'd1, 4'd1), "tmo_next");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
